// File: rtl/systolic_ctrl_if.sv
// Control bundle between a pass requester and the systolic array sequencer.
// Protocol: start is a level sampled on every rising clk edge; it is honoured
// only while the sequencer is idle (busy=0) and k_len is captured on that same
// edge. abort is honoured on any edge while busy=1. There is no ready signal:
// busy=0 is the only acceptance condition.
interface systolic_ctrl_if #(
    parameter int N  = 2,
    parameter int KW = 8
);
    // Requester -> sequencer
    logic                   start;
    logic [KW-1:0]          k_len;
    logic                   abort;

    // Sequencer -> requester / datapath
    logic                   busy;
    logic                   done;
    logic                   feed_en;
    logic [KW-1:0]          feed_idx;
    logic [N-1:0][N-1:0]    en_mult;
    logic [N-1:0][N-1:0]    clr_mult;
    logic [N-1:0][N-1:0]    en_accum;
    logic [N-1:0][N-1:0]    clr_accum;
    logic [N-1:0][N-1:0]    accum_start;

    // Requester side
    modport master (
        output start, k_len, abort,
        input  busy, done, feed_en, feed_idx,
        input  en_mult, clr_mult, en_accum, clr_accum, accum_start
    );

    // Sequencer side
    modport slave (
        input  start, k_len, abort,
        output busy, done, feed_en, feed_idx,
        output en_mult, clr_mult, en_accum, clr_accum, accum_start
    );
endinterface

// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N output-stationary systolic array.
// One pass: CLEAR (one cycle) -> FEED (K operand cycles) -> DRAIN (wavefront
// reaches the far corner) -> DONE (one-cycle pulse). PE(i,j) sees operand k
// at pass count c = i+j+k, so its multiply window is [d, d+K) and its
// accumulate window trails by one cycle, with d = i+j.
// All outputs are decoded from the registered state, pass counter and K.
// dbg_state encoding: 0 IDLE, 1 CLEAR, 2 FEED, 3 DRAIN, 4 DONE.
module systolic_ctrl #(
    parameter int N  = 2,
    parameter int KW = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    systolic_ctrl_if.slave      bus,
    output logic [2:0]          dbg_state
);

    // The counter must reach K_max + 2(N-1) + 1 without wrapping.
    localparam int CW = $clog2((1 << KW) + 2 * N);
    localparam logic [CW-1:0] SKEW_MAX = CW'(2 * (N - 1));

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      c_q, c_d;
    logic [KW-1:0]      k_q, k_d;
    logic [CW-1:0]      k_ext;

    logic                   busy_w;
    logic                   done_w;
    logic                   feed_en_w;
    logic [KW-1:0]          feed_idx_w;
    logic                   pe_active;
    logic [N-1:0][N-1:0]    en_mult_w;
    logic [N-1:0][N-1:0]    clr_w;
    logic [N-1:0][N-1:0]    en_accum_w;
    logic [N-1:0][N-1:0]    accum_start_w;

    assign k_ext     = CW'(k_q);
    assign dbg_state = state_q;

    // State, pass counter and latched K registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            k_q     <= k_d;
        end
    end

    // Next-state logic; abort outranks every other transition once busy.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        k_d     = k_q;
        if (state_q != S_IDLE && bus.abort) begin
            state_d = S_IDLE;
            c_d     = '0;
            k_d     = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    c_d = '0;
                    if (bus.start) begin
                        k_d     = bus.k_len;
                        state_d = S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    c_d     = '0;
                    state_d = (k_q != '0) ? S_FEED : S_DONE;
                end
                S_FEED: begin
                    c_d = c_q + CW'(1);
                    if (c_q == k_ext - CW'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    c_d = c_q + CW'(1);
                    if (c_q == k_ext + SKEW_MAX) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    c_d     = '0;
                    state_d = S_IDLE;
                end
                default: begin
                    c_d     = '0;
                    k_d     = '0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Global Moore outputs decoded from the registered state and counter.
    always_comb begin
        busy_w     = (state_q != S_IDLE);
        done_w     = (state_q == S_DONE);
        feed_en_w  = (state_q == S_FEED);
        feed_idx_w = feed_en_w ? c_q[KW-1:0] : '0;
        pe_active  = (state_q == S_FEED) || (state_q == S_DRAIN);
        clr_w      = (state_q == S_CLEAR) ? '1 : '0;
    end

    // Per-PE windows skewed by d = i+j; d+K+1 never exceeds the counter range.
    always_comb begin
        en_mult_w     = '0;
        en_accum_w    = '0;
        accum_start_w = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                en_mult_w[i][j]     = pe_active
                                      && (c_q >= CW'(i + j))
                                      && (c_q <  CW'(i + j) + k_ext);
                en_accum_w[i][j]    = pe_active
                                      && (c_q >= CW'(i + j + 1))
                                      && (c_q <  CW'(i + j + 1) + k_ext);
                accum_start_w[i][j] = pe_active && (c_q == CW'(i + j + 1));
            end
        end
    end

    assign bus.busy        = busy_w;
    assign bus.done        = done_w;
    assign bus.feed_en     = feed_en_w;
    assign bus.feed_idx    = feed_idx_w;
    assign bus.en_mult     = en_mult_w;
    assign bus.clr_mult    = clr_w;
    assign bus.en_accum    = en_accum_w;
    assign bus.clr_accum   = clr_w;
    assign bus.accum_start = accum_start_w;

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 SHALL have parameter N, default 2, meaning systolic array dimension (N x N PEs).
REQ-002 SHALL have parameter KW, default 8, meaning width of the reduction-length input.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-005 SHALL have port start, input, 1, meaning request one matrix-multiply pass.
REQ-006 SHALL have port k_len, input, KW, meaning reduction length K, sampled with start.
REQ-007 SHALL have port abort, input, 1, meaning cancel the pass in progress.
REQ-008 SHALL have port busy, output, 1, meaning high in every state except IDLE.
REQ-009 SHALL have port done, output, 1, meaning one-cycle pulse: results in the array are final.
REQ-010 SHALL have port feed_en, output, 1, meaning the upstream a/w streams present operand k this cycle.
REQ-011 SHALL have port feed_idx, output, KW, meaning k index of the current feed cycle.
REQ-012 SHALL have ports en_mult, clr_mult, en_accum, clr_accum, accum_start, each output [N-1:0][N-1:0], meaning per-PE MAC controls.

Function
REQ-013 SHALL implement FSM states IDLE, CLEAR, FEED, DRAIN, DONE; all outputs are decoded from registered state and counters (Moore).
REQ-014 SHALL, in IDLE with start=1, latch K=k_len and go to CLEAR; start is ignored in every other state.
REQ-015 SHALL hold CLEAR exactly one cycle with all clr_mult and clr_accum bits =1, all enables =0.
REQ-016 SHALL leave CLEAR to FEED if K!=0, else directly to DONE (no enables ever asserted, results zero).
REQ-017 SHALL run a pass counter c: c=0 in the first FEED cycle, +1 every FEED/DRAIN cycle.
REQ-018 SHALL stay in FEED for c=0..K-1 with feed_en=1 and feed_idx=c; feed_en=0 and feed_idx=0 otherwise.
REQ-019 SHALL stay in DRAIN for c=K..K+2(N-1), then go to DONE.
REQ-020 SHALL, with skew d=i+j for PE(i,j), assert en_mult[i][j] iff in FEED/DRAIN and d <= c < d+K.
REQ-021 SHALL assert en_accum[i][j] iff in FEED/DRAIN and d+1 <= c < d+K+1.
REQ-022 SHALL assert accum_start[i][j] iff in FEED/DRAIN and c==d+1 (first accumulate cycle of that PE).
REQ-023 SHALL hold DONE one cycle with done=1, then return to IDLE; a start in that cycle is ignored.
REQ-024 SHALL, on abort=1 in any non-IDLE state, go to IDLE next cycle with all outputs 0, done not pulsed; abort in IDLE has no effect; abort has priority over every other transition.
REQ-025 SHALL size c to hold K_max+2(N-1)+1 without wrap; K=2^KW-1 is legal.

Reset
REQ-026 SHALL, while rst_n=0 at a clock edge, enter IDLE with c=0, K=0 and busy, done, feed_en, feed_idx and all per-PE controls 0 the following cycle, regardless of state (mid-pass included).
REQ-027 SHALL ignore start and abort in any cycle where rst_n=0.

Verification
REQ-028 N=2, start with k_len=4 at edge E0 -> CLEAR cycle after E0, feed_en high 4 cycles with feed_idx 0,1,2,3; en_mult[0][0] at c0-3, [0][1]/[1][0] at c1-4, [1][1] at c2-5; accum_start[1][1] only at c3; done one cycle at c7; busy drops after.
REQ-029 k_len=0 -> CLEAR one cycle, DONE next cycle, no en_mult/en_accum/feed_en ever high.
REQ-030 k_len=255 -> feed_en exactly 255 cycles, last en_accum[1][1] at c=257, done at c=258, no counter wrap.
REQ-031 abort at c=2 of a K=4 pass -> next cycle all outputs 0, state IDLE, done never pulses; a new start then runs a full correct pass.
REQ-032 rst_n=0 for one cycle during DRAIN -> all outputs 0 next cycle; start held high during reset ignored; start after reset accepted normally.
REQ-033 start pulsed during FEED and during the DONE cycle -> ignored; pass timing unchanged, no second pass.
